// File: rtl/alu_exec_stage.sv
// Execute stage: applies ALUOP to ID/EX operands and registers result, flags and forwarded control into EX/MEM.
// Optional signed-overflow flag enabled by defining ALU_OVF_EN; otherwise ovf is tied to 0.
module alu_exec_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2:0]            alu_op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  zero,
  output logic                  illegal_op,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [COUNT_W-1:0]    op_count,
  output logic                  ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  logic signed [DATA_W-1:0] w_a_p0;
  logic signed [DATA_W-1:0] w_b_p0;
  logic signed [DATA_W-1:0] w_result_p0;
  logic                     w_illegal_p0;
  logic                     w_capture_p0;
  logic                     w_bubble_p0;

  logic                  r_vld_p1;
  logic [DATA_W-1:0]     r_result_p1;
  logic                  r_zero_p1;
  logic                  r_illegal_p1;
  logic [REG_ADDR_W-1:0] r_rd_p1;
  logic                  r_reg_write_p1;
  logic                  r_mem_read_p1;
  logic                  r_mem_write_p1;
  logic [DATA_W-1:0]     r_store_data_p1;
  logic [COUNT_W-1:0]    r_op_count;

  // Stage p0: combinational ALU on the ID/EX operands
  assign w_a_p0 = signed'(src_a);
  assign w_b_p0 = signed'(src_b);

  always_comb begin
    w_result_p0  = '0;
    w_illegal_p0 = 1'b0;
    case (alu_op)
      OP_ADD:  w_result_p0 = w_a_p0 + w_b_p0;
      OP_SUB:  w_result_p0 = w_a_p0 - w_b_p0;
      OP_OR:   w_result_p0 = w_a_p0 | w_b_p0;
      OP_NOR:  w_result_p0 = ~(w_a_p0 | w_b_p0);
      OP_AND:  w_result_p0 = w_a_p0 & w_b_p0;
      default: w_illegal_p0 = 1'b1;
    endcase
  end

  assign w_capture_p0 = !flush && !stall && in_valid;
  assign w_bubble_p0  = flush || (!stall && !in_valid);

  // Stage p1: EX/MEM register; flush outranks stall, stall outranks capture/bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1        <= 1'b0;
      r_result_p1     <= '0;
      r_zero_p1       <= 1'b0;
      r_illegal_p1    <= 1'b0;
      r_rd_p1         <= '0;
      r_reg_write_p1  <= 1'b0;
      r_mem_read_p1   <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_store_data_p1 <= '0;
    end else if (w_bubble_p0) begin
      r_vld_p1        <= 1'b0;
      r_result_p1     <= '0;
      r_zero_p1       <= 1'b1;
      r_illegal_p1    <= 1'b0;
      r_rd_p1         <= '0;
      r_reg_write_p1  <= 1'b0;
      r_mem_read_p1   <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_store_data_p1 <= '0;
    end else if (w_capture_p0) begin
      r_vld_p1        <= 1'b1;
      r_result_p1     <= w_result_p0;
      r_zero_p1       <= (w_result_p0 == '0);
      r_illegal_p1    <= w_illegal_p0;
      r_rd_p1         <= rd_in;
      // Illegal slots stay visible to hazard logic but must not write anything.
      r_reg_write_p1  <= reg_write_in & ~w_illegal_p0;
      r_mem_read_p1   <= mem_read_in  & ~w_illegal_p0;
      r_mem_write_p1  <= mem_write_in & ~w_illegal_p0;
      r_store_data_p1 <= store_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (cnt_clr) begin
      r_op_count <= '0;
    end else if (w_capture_p0) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

`ifdef ALU_OVF_EN
  logic r_ovf_p1;

  function automatic logic calc_ovf(input logic [2:0] op,
                                    input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
    logic v;
    v = 1'b0;
    if (op == OP_ADD)
      v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    else if (op == OP_SUB)
      v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_p1 <= 1'b0;
    else if (w_bubble_p0)
      r_ovf_p1 <= 1'b0;
    else if (w_capture_p0)
      r_ovf_p1 <= calc_ovf(alu_op, w_a_p0, w_b_p0, w_result_p0);
  end

  assign ovf = r_ovf_p1;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid      = r_vld_p1;
  assign alu_result     = r_result_p1;
  assign zero           = r_zero_p1;
  assign illegal_op     = r_illegal_p1;
  assign rd_out         = r_rd_p1;
  assign reg_write_out  = r_reg_write_p1;
  assign mem_read_out   = r_mem_read_p1;
  assign mem_write_out  = r_mem_write_p1;
  assign store_data_out = r_store_data_p1;
  assign op_count       = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (counter built 4 bits wide to exercise wrap).
module tb_alu_exec_stage;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [2:0]    alu_op;
  logic [DW-1:0] src_a, src_b;
  logic [AW-1:0] rd_in;
  logic          reg_write_in, mem_read_in, mem_write_in;
  logic [DW-1:0] store_data_in;
  logic          stall, flush, cnt_clr;
  logic          out_valid;
  logic [DW-1:0] alu_result;
  logic          zero, illegal_op;
  logic [AW-1:0] rd_out;
  logic          reg_write_out, mem_read_out, mem_write_out;
  logic [DW-1:0] store_data_out;
  logic [CW-1:0] op_count;
  logic          ovf;

  int checks = 0;
  int failures = 0;

  alu_exec_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .store_data_in(store_data_in), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
    .illegal_op(illegal_op), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .store_data_out(store_data_out), .op_count(op_count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    in_valid = v;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, alu_result, zero, illegal_op, rd_out, reg_write_out, mem_read_out,
         mem_write_out, store_data_out, op_count, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_init: out_valid=%b result=%h zero=%b op_count=%0d expected all 0",
               out_valid, alu_result, zero, op_count);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b000, 16'(i), 16'd1);
      tick();
    end
    checks++;
    if (op_count !== 4'd5) begin
      failures++;
      $display("FAIL reset_precount: op_count=%0d expected 5", op_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 16'h0 || zero !== 1'b0 || op_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b result=%h zero=%b op_count=%0d expected 0/0000/0/0",
               out_valid, alu_result, zero, op_count);
    end
    #2;
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 16'd3, 16'd4);
    tick();
    checks++;
    if (alu_result !== 16'd7 || out_valid !== 1'b1 || op_count !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_add: result=%h valid=%b op_count=%0d expected 0007/1/1",
               alu_result, out_valid, op_count);
    end
  endtask

  task automatic test_ops();
    logic [2:0]    ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [DW-1:0] exp [5] = '{16'h00E0, 16'hE100, 16'hFFF0, 16'h000F, 16'h00F0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 16'hF0F0, 16'h0FF0);
      tick();
      checks++;
      if (alu_result !== exp[i] || out_valid !== 1'b1 || zero !== 1'b0 || illegal_op !== 1'b0) begin
        failures++;
        $display("FAIL op_%0d: result=%h valid=%b zero=%b illegal=%b expected %h/1/0/0",
                 i, alu_result, out_valid, zero, illegal_op, exp[i]);
      end
    end
  endtask

  task automatic test_zero_illegal();
    drive(1'b1, 3'b001, 16'd5, 16'd5);
    rd_in = 3'd5; reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b1;
    store_data_in = 16'hBEEF;
    tick();
    checks++;
    if (alu_result !== 16'h0 || zero !== 1'b1 || rd_out !== 3'd5 || reg_write_out !== 1'b1 ||
        mem_write_out !== 1'b1 || store_data_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL sub_zero_fwd: result=%h zero=%b rd=%0d rw=%b mw=%b sd=%h expected 0000/1/5/1/1/beef",
               alu_result, zero, rd_out, reg_write_out, mem_write_out, store_data_out);
    end
    drive(1'b1, 3'b110, 16'h1234, 16'h5678);
    mem_read_in = 1'b1;
    tick();
    checks++;
    if (alu_result !== 16'h0 || illegal_op !== 1'b1 || reg_write_out !== 1'b0 ||
        mem_read_out !== 1'b0 || mem_write_out !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL illegal: result=%h ill=%b rw=%b mr=%b mw=%b valid=%b expected 0000/1/0/0/0/1",
               alu_result, illegal_op, reg_write_out, mem_read_out, mem_write_out, out_valid);
    end
    reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    rd_in = '0; store_data_in = '0;
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] c;
    drive(1'b1, 3'b000, 16'd1, 16'd1);
    tick();
    c = op_count;
    stall = 1'b1;
    drive(1'b1, 3'b000, 16'd5, 16'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (alu_result !== 16'd2 || out_valid !== 1'b1 || op_count !== c) begin
        failures++;
        $display("FAIL stall_%0d: result=%h valid=%b op_count=%0d expected 0002/1/%0d",
                 i, alu_result, out_valid, op_count, c);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || zero !== 1'b1 || alu_result !== 16'h0 || op_count !== c) begin
      failures++;
      $display("FAIL stall_flush: valid=%b zero=%b result=%h op_count=%0d expected 0/1/0000/%0d",
               out_valid, zero, alu_result, op_count, c);
    end
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'b010, 16'h00F0, 16'h0F00);
    tick();
    drive(1'b0, 3'b010, 16'h00F0, 16'h0F00);
    tick();
    checks++;
    if (out_valid !== 1'b0 || zero !== 1'b1 || alu_result !== 16'h0 || op_count !== c + 4'd1) begin
      failures++;
      $display("FAIL bubble: valid=%b zero=%b result=%h op_count=%0d expected 0/1/0000/%0d",
               out_valid, zero, alu_result, op_count, c + 4'd1);
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    drive(1'b1, 3'b000, 16'd2, 16'd2);
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (op_count !== 4'd0 || alu_result !== 16'd4) begin
      failures++;
      $display("FAIL clr_with_valid: op_count=%0d result=%h expected 0/0004", op_count, alu_result);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (op_count !== 4'd15) begin
      failures++;
      $display("FAIL count_15: op_count=%0d expected 15", op_count);
    end
    tick();
    checks++;
    if (op_count !== 4'd0) begin
      failures++;
      $display("FAIL count_wrap: op_count=%0d expected 0", op_count);
    end
    tick(); tick();
    stall = 1'b1; cnt_clr = 1'b1;
    tick();
    stall = 1'b0; cnt_clr = 1'b0;
    checks++;
    if (op_count !== 4'd0) begin
      failures++;
      $display("FAIL clr_in_stall: op_count=%0d expected 0", op_count);
    end
  endtask

  task automatic test_ovf();
    logic en;
`ifdef ALU_OVF_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    drive(1'b1, 3'b000, 16'h7FFF, 16'h0001);
    tick();
    checks++;
    if (ovf !== en || alu_result !== 16'h8000) begin
      failures++;
      $display("FAIL ovf_add: ovf=%b result=%h expected %b/8000", ovf, alu_result, en);
    end
    drive(1'b1, 3'b001, 16'h8000, 16'h0001);
    tick();
    checks++;
    if (ovf !== en || alu_result !== 16'h7FFF) begin
      failures++;
      $display("FAIL ovf_sub: ovf=%b result=%h expected %b/7fff", ovf, alu_result, en);
    end
    drive(1'b1, 3'b000, 16'h0001, 16'h0001);
    tick();
    checks++;
    if (ovf !== 1'b0 || alu_result !== 16'h0002) begin
      failures++;
      $display("FAIL ovf_none: ovf=%b result=%h expected 0/0002", ovf, alu_result);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 3'b000, '0, '0);
    rd_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    store_data_in = '0;
    test_reset();
    test_ops();
    test_zero_illegal();
    test_stall_flush();
    test_counter();
    test_ovf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
